// File: rtl/demux_4f_to_f.sv
// Serial-to-parallel demux: one byte per clk_4f cycle in, four lanes updated together once per frame.
// Slot order on the lanes is fixed (0->0, 1->2, 2->1, 3->3); sync realigns the frame to slot 0.
module demux_4f_to_f #(
    parameter int DATA_W = 8
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_000,
    input  logic              valid_000,
    input  logic              sync,
    output logic [DATA_W-1:0] data_0,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [DATA_W-1:0] data_3,
    output logic              valid_0,
    output logic              valid_1,
    output logic              valid_2,
    output logic              valid_3,
    output logic              frame_stb,
    output logic              sync_err
);

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;

    logic [1:0]        slot;
    logic [DATA_W-1:0] in_data;
    logic              realign;

    // Staging for lanes 0, 1 and 2; lane 3 loads straight from the input.
    logic [DATA_W-1:0] stg_data_0, stg_data_1, stg_data_2;
    logic              stg_valid_0, stg_valid_1, stg_valid_2;

    // An unqualified byte is carried as zero so a lane never shows stale data with valid low.
    assign in_data = valid_000 ? data_000 : '0;
    assign realign = sync && (slot != SLOT0);

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            slot        <= SLOT0;
            stg_data_0  <= '0;
            stg_data_1  <= '0;
            stg_data_2  <= '0;
            stg_valid_0 <= 1'b0;
            stg_valid_1 <= 1'b0;
            stg_valid_2 <= 1'b0;
            data_0      <= '0;
            data_1      <= '0;
            data_2      <= '0;
            data_3      <= '0;
            valid_0     <= 1'b0;
            valid_1     <= 1'b0;
            valid_2     <= 1'b0;
            valid_3     <= 1'b0;
            frame_stb   <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            sync_err  <= 1'b0;
            if (realign) begin
                // Drop the partial frame; this byte restarts the frame as slot 0.
                slot        <= SLOT1;
                stg_data_0  <= in_data;
                stg_valid_0 <= valid_000;
                stg_data_1  <= '0;
                stg_valid_1 <= 1'b0;
                stg_data_2  <= '0;
                stg_valid_2 <= 1'b0;
                sync_err    <= 1'b1;
            end else begin
                slot <= slot + 2'd1;
                case (slot)
                    SLOT0: begin
                        stg_data_0  <= in_data;
                        stg_valid_0 <= valid_000;
                    end
                    SLOT1: begin
                        stg_data_2  <= in_data;
                        stg_valid_2 <= valid_000;
                    end
                    SLOT2: begin
                        stg_data_1  <= in_data;
                        stg_valid_1 <= valid_000;
                    end
                    SLOT3: begin
                        data_0    <= stg_data_0;
                        data_1    <= stg_data_1;
                        data_2    <= stg_data_2;
                        data_3    <= in_data;
                        valid_0   <= stg_valid_0;
                        valid_1   <= stg_valid_1;
                        valid_2   <= stg_valid_2;
                        valid_3   <= valid_000;
                        frame_stb <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_4f_to_f.sv
// Bench for demux_4f_to_f: frame-buffer reference model compared every cycle, plus
// directed frames with literal expectations and a randomized stream.
module tb_demux_4f_to_f;

    logic       clk_4f;
    logic       reset_L;
    logic [7:0] data_000;
    logic       valid_000;
    logic       sync;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic       frame_stb, sync_err;

    demux_4f_to_f #(.DATA_W(8)) dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .data_000  (data_000),
        .valid_000 (valid_000),
        .sync      (sync),
        .data_0    (data_0),
        .data_1    (data_1),
        .data_2    (data_2),
        .data_3    (data_3),
        .valid_0   (valid_0),
        .valid_1   (valid_1),
        .valid_2   (valid_2),
        .valid_3   (valid_3),
        .frame_stb (frame_stb),
        .sync_err  (sync_err)
    );

    // Clock / reset
    initial begin
        clk_4f = 1'b0;
        forever #5 clk_4f = ~clk_4f;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes collected by frame position, scattered to lanes on completion.
    localparam int SLOT_LANE[4] = '{0, 2, 1, 3};
    logic [7:0] fb_d[4];
    logic       fb_v[4];
    logic [7:0] m_d[4];
    logic       m_v[4];
    logic       m_stb, m_err;
    int         pos;
    logic [7:0] smp_d;
    assign smp_d = valid_000 ? data_000 : 8'h00;

    always @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            pos   <= 0;
            m_stb <= 1'b0;
            m_err <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                fb_d[k] <= 8'h00;
                fb_v[k] <= 1'b0;
                m_d[k]  <= 8'h00;
                m_v[k]  <= 1'b0;
            end
        end else begin
            m_stb <= 1'b0;
            m_err <= 1'b0;
            if (sync && pos != 0) begin
                for (int k = 1; k < 4; k++) begin
                    fb_d[k] <= 8'h00;
                    fb_v[k] <= 1'b0;
                end
                fb_d[0] <= smp_d;
                fb_v[0] <= valid_000;
                pos     <= 1;
                m_err   <= 1'b1;
            end else if (pos == 3) begin
                for (int k = 0; k < 3; k++) begin
                    m_d[SLOT_LANE[k]] <= fb_d[k];
                    m_v[SLOT_LANE[k]] <= fb_v[k];
                end
                m_d[3] <= smp_d;
                m_v[3] <= valid_000;
                m_stb  <= 1'b1;
                pos    <= 0;
            end else begin
                fb_d[pos] <= smp_d;
                fb_v[pos] <= valid_000;
                pos       <= pos + 1;
            end
        end
    end

    // Scoreboard compare on every falling edge
    always @(negedge clk_4f) begin
        if (chk_en) begin
            check("data_0", {24'h0, data_0}, {24'h0, m_d[0]});
            check("data_1", {24'h0, data_1}, {24'h0, m_d[1]});
            check("data_2", {24'h0, data_2}, {24'h0, m_d[2]});
            check("data_3", {24'h0, data_3}, {24'h0, m_d[3]});
            check("valid_0", {31'h0, valid_0}, {31'h0, m_v[0]});
            check("valid_1", {31'h0, valid_1}, {31'h0, m_v[1]});
            check("valid_2", {31'h0, valid_2}, {31'h0, m_v[2]});
            check("valid_3", {31'h0, valid_3}, {31'h0, m_v[3]});
            check("frame_stb", {31'h0, frame_stb}, {31'h0, m_stb});
            check("sync_err", {31'h0, sync_err}, {31'h0, m_err});
        end
    end

    // Driver tasks
    task automatic send(input logic [7:0] d, input logic v, input logic s);
        data_000  = d;
        valid_000 = v;
        sync      = s;
        @(posedge clk_4f);
        @(negedge clk_4f);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d"}, {data_0, data_1, data_2, data_3}, 32'h0);
        check({tag, "_v"}, {28'h0, valid_0, valid_1, valid_2, valid_3}, 32'h0);
        check({tag, "_stb_err"}, {30'h0, frame_stb, sync_err}, 32'h0);
    endtask

    task automatic check_lanes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] ev);
        check({tag, "_d0"}, {24'h0, data_0}, {24'h0, e0});
        check({tag, "_d1"}, {24'h0, data_1}, {24'h0, e1});
        check({tag, "_d2"}, {24'h0, data_2}, {24'h0, e2});
        check({tag, "_d3"}, {24'h0, data_3}, {24'h0, e3});
        check({tag, "_v"}, {28'h0, valid_0, valid_1, valid_2, valid_3}, {28'h0, ev});
    endtask

    int stb_cnt;
    int err_cnt;

    initial begin
        reset_L   = 1'b0;
        data_000  = 8'h00;
        valid_000 = 1'b0;
        sync      = 1'b0;
        repeat (2) @(negedge clk_4f);
        check_all_zero("reset");
        chk_en  = 1'b1;
        reset_L = 1'b1;

        // First frame after reset
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b1, 1'b0);
        check_lanes("first_frame", 8'hA0, 8'hA2, 8'hA1, 8'hA3, 4'b1111);
        check("first_stb", {31'h0, frame_stb}, 32'h1);
        send(8'h00, 1'b0, 1'b0);
        check("first_stb_drop", {31'h0, frame_stb}, 32'h0);
        for (int i = 0; i < 3; i++) send(8'h00, 1'b0, 1'b0);

        // Continuous stream 0x00..0x0F
        stb_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b1, 1'b0);
            if (frame_stb) stb_cnt++;
        end
        check("stream_stb_count", stb_cnt, 4);
        check_lanes("stream_f4", 8'h0C, 8'h0E, 8'h0D, 8'h0F, 4'b1111);

        // Invalid byte in slot 1
        send(8'h50, 1'b1, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        send(8'h56, 1'b1, 1'b0);
        send(8'h57, 1'b1, 1'b0);
        check_lanes("invalid_slot1", 8'h50, 8'h56, 8'h00, 8'h57, 4'b1101);

        // Sync on slot 2 realigns
        send(8'h60, 1'b1, 1'b0);
        send(8'h61, 1'b1, 1'b0);
        send(8'hB0, 1'b1, 1'b1);
        check("sync2_err", {31'h0, sync_err}, 32'h1);
        stb_cnt = 0;
        send(8'hB1, 1'b1, 1'b0);
        if (frame_stb) stb_cnt++;
        check("sync2_err_drop", {31'h0, sync_err}, 32'h0);
        send(8'hB2, 1'b1, 1'b0);
        if (frame_stb) stb_cnt++;
        check("sync2_no_partial_stb", stb_cnt, 0);
        send(8'hB3, 1'b1, 1'b0);
        check("sync2_stb", {31'h0, frame_stb}, 32'h1);
        check_lanes("sync2_frame", 8'hB0, 8'hB2, 8'hB1, 8'hB3, 4'b1111);

        // Sync on what would be slot 3 wins over the load
        for (int i = 0; i < 3; i++) send(8'h70 + 8'(i), 1'b1, 1'b0);
        send(8'hD0, 1'b1, 1'b1);
        check("sync3_no_stb", {31'h0, frame_stb}, 32'h0);
        check("sync3_err", {31'h0, sync_err}, 32'h1);
        for (int i = 1; i < 4; i++) send(8'hD0 + 8'(i), 1'b1, 1'b0);
        check_lanes("sync3_frame", 8'hD0, 8'hD2, 8'hD1, 8'hD3, 4'b1111);

        // Aligned sync every frame: no error, normal cadence
        stb_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            send(8'h80 + 8'(i), 1'b1, (i % 4) == 0);
            if (frame_stb) stb_cnt++;
            if (sync_err) err_cnt++;
        end
        check("aligned_sync_err", err_cnt, 0);
        check("aligned_sync_stb", stb_cnt, 3);

        // Reset mid-frame
        send(8'hE0, 1'b1, 1'b0);
        send(8'hE1, 1'b1, 1'b0);
        valid_000 = 1'b0;
        reset_L   = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk_4f);
        reset_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(8'hC0 + 8'(i), 1'b1, 1'b0);
            check_all_zero("post_reset_hold");
        end
        send(8'hC3, 1'b1, 1'b0);
        check_lanes("post_reset_frame", 8'hC0, 8'hC2, 8'hC1, 8'hC3, 4'b1111);

        // Randomized stream with occasional sync
        for (int i = 0; i < 400; i++) begin
            send(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
